dcache_controller: RTL and testbench

Direct-mapped, write-back, write-allocate data cache sitting between the CPU load/store unit and the 128-bit block data memory. It serves 32-bit word reads and writes from a local line store. On a miss it acts as the initiator of the block-memory protocol: it writes back a dirty victim, fetches the new 16-byte block, and then completes the CPU access.

---
 rtl/dcache_pkg.sv | 21 ++
 rtl/dcache_if.sv | 22 ++
 rtl/dcache_line_store.sv | 59 +++++
 rtl/dcache_controller.sv | 136 +++++++++++++
 tb/tb_dcache_controller.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-back data cache.
// Address layout: [31:4+INDEX_BITS] tag, [3+INDEX_BITS:4] index, [3:2] word select.
package dcache_pkg;

    localparam int unsigned BLOCK_BITS      = 128;
    localparam int unsigned WORD_BITS       = 32;
    localparam int unsigned MEM_ADDR_BITS   = 28;
    localparam int unsigned WORDS_PER_BLOCK = BLOCK_BITS / WORD_BITS;

    localparam int unsigned WORD_SEL_LSB  = 2;
    localparam int unsigned WORD_SEL_BITS = 2;
    localparam int unsigned OFFSET_BITS   = 4;

    typedef enum logic [1:0] {
        StIdle,
        StWriteback,
        StFetch,
        StAllocate
    } state_e;

endpackage

// File: rtl/dcache_if.sv
// Block-memory bus between the cache (master, initiator) and the data memory (slave).
interface dcache_if;
    import dcache_pkg::*;

    logic                     mem_read;
    logic                     mem_write;
    logic [MEM_ADDR_BITS-1:0] mem_address;
    logic [BLOCK_BITS-1:0]    mem_writedata;
    logic [BLOCK_BITS-1:0]    mem_readdata;
    logic                     mem_busywait;

    modport master (
        output mem_read, mem_write, mem_address, mem_writedata,
        input  mem_readdata, mem_busywait
    );

    modport slave (
        input  mem_read, mem_write, mem_address, mem_writedata,
        output mem_readdata, mem_busywait
    );

endinterface

// File: rtl/dcache_line_store.sv
// Valid/dirty/tag/data arrays of the cache. Only valid and dirty are cleared by reset;
// tag and data are plain storage.
module dcache_line_store
    import dcache_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 3,
    parameter int unsigned TAG_BITS   = 25
) (
    input  logic                          clock,
    input  logic                          clear,
    input  logic [INDEX_BITS-1:0]         rd_index,
    output logic                          rd_valid,
    output logic                          rd_dirty,
    output logic [TAG_BITS-1:0]           rd_tag,
    output logic [BLOCK_BITS-1:0]         rd_data,
    input  logic                          word_we,
    input  logic [INDEX_BITS-1:0]         word_index,
    input  logic [WORD_SEL_BITS-1:0]      word_sel,
    input  logic [WORD_BITS-1:0]          word_data,
    input  logic                          fill_en,
    input  logic [INDEX_BITS-1:0]         fill_index,
    input  logic [TAG_BITS-1:0]           fill_tag,
    input  logic [BLOCK_BITS-1:0]         fill_block
);

    localparam int unsigned LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]    valid_q;
    logic [LINES-1:0]    dirty_q;
    logic [TAG_BITS-1:0] tag_q [LINES];
    logic [WORDS_PER_BLOCK-1:0][WORD_BITS-1:0] data_q [LINES];

    assign rd_valid = valid_q[rd_index];
    assign rd_dirty = dirty_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index];

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_en) begin
            valid_q[fill_index] <= 1'b1;
            dirty_q[fill_index] <= 1'b0;
        end else if (word_we) begin
            dirty_q[word_index] <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (fill_en) begin
            tag_q[fill_index]  <= fill_tag;
            data_q[fill_index] <= fill_block;
        end else if (word_we) begin
            data_q[word_index][word_sel] <= word_data;
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate data cache: hit logic and miss FSM
// (write back dirty victim, fetch block, allocate, then serve the access as a hit).
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_address,
    input  logic [31:0] cpu_writedata,
    output logic [31:0] cpu_readdata,
    output logic        cpu_busywait,
    dcache_if.master    mem
);

    localparam int unsigned TAG_BITS = MEM_ADDR_BITS - INDEX_BITS;

    logic [INDEX_BITS-1:0]    index;
    logic [TAG_BITS-1:0]      tag;
    logic [WORD_SEL_BITS-1:0] word_sel;
    logic                     unused_addr;

    assign index       = cpu_address[OFFSET_BITS +: INDEX_BITS];
    assign tag         = cpu_address[31 -: TAG_BITS];
    assign word_sel    = cpu_address[WORD_SEL_LSB +: WORD_SEL_BITS];
    assign unused_addr = ^cpu_address[1:0];

    logic                  line_valid;
    logic                  line_dirty;
    logic [TAG_BITS-1:0]   line_tag;
    logic [BLOCK_BITS-1:0] line_data;
    logic [WORDS_PER_BLOCK-1:0][WORD_BITS-1:0] line_words;

    state_e state_q;
    logic   mem_read_q;
    logic   mem_write_q;
    logic   req;
    logic   hit;
    logic   word_we;
    logic   fill_en;

    // Simultaneous read and write is illegal and treated as no request at all.
    assign req        = cpu_read ^ cpu_write;
    assign hit        = line_valid && (line_tag == tag);
    assign line_words = line_data;
    assign word_we    = (state_q == StIdle) && cpu_write && !cpu_read && hit;
    assign fill_en    = (state_q == StAllocate);

    dcache_line_store #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_line_store (
        .clock      (clock),
        .clear      (reset),
        .rd_index   (index),
        .rd_valid   (line_valid),
        .rd_dirty   (line_dirty),
        .rd_tag     (line_tag),
        .rd_data    (line_data),
        .word_we    (word_we),
        .word_index (index),
        .word_sel   (word_sel),
        .word_data  (cpu_writedata),
        .fill_en    (fill_en),
        .fill_index (index),
        .fill_tag   (tag),
        .fill_block (mem.mem_readdata)
    );

    always_comb begin
        cpu_readdata = '0;
        cpu_busywait = 1'b0;
        if (!reset) begin
            if (state_q != StIdle) begin
                cpu_busywait = 1'b1;
            end else if (req && !hit) begin
                cpu_busywait = 1'b1;
            end else if (cpu_read && !cpu_write && hit) begin
                cpu_readdata = line_words[word_sel];
            end
        end
    end

    assign mem.mem_read      = mem_read_q;
    assign mem.mem_write     = mem_write_q;
    assign mem.mem_address   = (state_q == StWriteback) ? {line_tag, index}
                                                        : cpu_address[31:OFFSET_BITS];
    assign mem.mem_writedata = line_data;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req && !hit) begin
                        if (line_valid && line_dirty) begin
                            state_q     <= StWriteback;
                            mem_write_q <= 1'b1;
                        end else begin
                            state_q    <= StFetch;
                            mem_read_q <= 1'b1;
                        end
                    end
                end
                StWriteback: begin
                    if (!mem.mem_busywait) begin
                        state_q     <= StFetch;
                        mem_write_q <= 1'b0;
                        mem_read_q  <= 1'b1;
                    end
                end
                StFetch: begin
                    if (!mem.mem_busywait) begin
                        state_q    <= StAllocate;
                        mem_read_q <= 1'b0;
                    end
                end
                StAllocate: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q     <= StIdle;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a 16-cycle block memory model.
module tb_dcache_controller;
    import dcache_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_read = 1'b0;
    logic        cpu_write = 1'b0;
    logic [31:0] cpu_address = '0;
    logic [31:0] cpu_writedata = '0;
    logic [31:0] cpu_readdata;
    logic        cpu_busywait;

    int checks = 0;
    int failures = 0;

    dcache_if mif ();

    dcache_controller #(
        .INDEX_BITS (3)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .cpu_read      (cpu_read),
        .cpu_write     (cpu_write),
        .cpu_address   (cpu_address),
        .cpu_writedata (cpu_writedata),
        .cpu_readdata  (cpu_readdata),
        .cpu_busywait  (cpu_busywait),
        .mem           (mif)
    );

    always #5 clock = ~clock;

    // Memory model: busywait low in the 16th cycle of a request; reset reloads contents.
    logic [127:0] mem [0:255];
    int unsigned  mcnt;
    logic [27:0]  rd_addr_q;
    logic         mreq;

    assign mreq             = mif.mem_read || mif.mem_write;
    assign mif.mem_busywait = !(mreq && mcnt == 15);
    assign mif.mem_readdata = mem[rd_addr_q[7:0]];

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mcnt      <= 0;
            rd_addr_q <= '0;
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            mem[8'h04] <= 128'h44444444_33333333_22222222_11111111;
            mem[8'h0C] <= 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        end else if (mreq) begin
            if (mif.mem_read) rd_addr_q <= mif.mem_address;
            if (mcnt == 15) begin
                mcnt <= 0;
                if (mif.mem_write) mem[mif.mem_address[7:0]] <= mif.mem_writedata;
            end else begin
                mcnt <= mcnt + 1;
            end
        end else begin
            mcnt <= 0;
        end
    end

    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] data, output int bw, output int nrd,
                             output int nwr, output logic [27:0] rd_a,
                             output logic [27:0] wr_a, output logic [127:0] wr_d,
                             output logic [31:0] rdata, output logic moved,
                             output logic req_end);
        bw = 0; nrd = 0; nwr = 0; rd_a = '0; wr_a = '0; wr_d = '0; moved = 1'b0;
        @(negedge clock);
        cpu_read = rd; cpu_write = wr; cpu_address = addr; cpu_writedata = data;
        #1;
        while (cpu_busywait && bw < 100) begin
            bw++;
            if (mif.mem_read) begin
                if (nrd > 0 && mif.mem_address !== rd_a) moved = 1'b1;
                rd_a = mif.mem_address;
                nrd++;
            end
            if (mif.mem_write) begin
                if (nwr > 0 && (mif.mem_address !== wr_a || mif.mem_writedata !== wr_d))
                    moved = 1'b1;
                wr_a = mif.mem_address;
                wr_d = mif.mem_writedata;
                nwr++;
            end
            @(negedge clock);
            #1;
        end
        rdata   = cpu_readdata;
        req_end = mif.mem_read | mif.mem_write;
        @(negedge clock);
        cpu_read = 1'b0; cpu_write = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++; if (cpu_busywait !== 1'b0) begin failures++;
            $display("FAIL reset_busywait got=%b exp=0", cpu_busywait); end
        checks++; if (mif.mem_read !== 1'b0) begin failures++;
            $display("FAIL reset_mem_read got=%b exp=0", mif.mem_read); end
        checks++; if (mif.mem_write !== 1'b0) begin failures++;
            $display("FAIL reset_mem_write got=%b exp=0", mif.mem_write); end
        checks++; if (cpu_readdata !== 32'h0) begin failures++;
            $display("FAIL reset_readdata got=%h exp=0", cpu_readdata); end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_clean_miss();
        int bw, nrd, nwr; logic [27:0] ra, wa; logic [127:0] wd; logic [31:0] rdv;
        logic mv, re;
        do_access(1'b1, 1'b0, 32'h40, 32'h0, bw, nrd, nwr, ra, wa, wd, rdv, mv, re);
        checks++; if (bw !== 18) begin failures++;
            $display("FAIL clean_busy_cycles got=%0d exp=18", bw); end
        checks++; if (nrd !== 16) begin failures++;
            $display("FAIL clean_read_cycles got=%0d exp=16", nrd); end
        checks++; if (nwr !== 0) begin failures++;
            $display("FAIL clean_write_cycles got=%0d exp=0", nwr); end
        checks++; if (ra !== 28'h0000004 || mv !== 1'b0) begin failures++;
            $display("FAIL clean_read_addr got=%h moved=%b exp=0000004", ra, mv); end
        checks++; if (rdv !== 32'h11111111) begin failures++;
            $display("FAIL clean_readdata got=%h exp=11111111", rdv); end
    endtask

    task automatic test_read_hit();
        int bw, nrd, nwr; logic [27:0] ra, wa; logic [127:0] wd; logic [31:0] rdv;
        logic mv, re;
        do_access(1'b1, 1'b0, 32'h44, 32'h0, bw, nrd, nwr, ra, wa, wd, rdv, mv, re);
        checks++; if (bw !== 0 || re !== 1'b0) begin failures++;
            $display("FAIL hit_busy got=%0d req=%b exp=0/0", bw, re); end
        checks++; if (rdv !== 32'h22222222) begin failures++;
            $display("FAIL hit_readdata got=%h exp=22222222", rdv); end
    endtask

    task automatic test_write_hit();
        int bw, nrd, nwr; logic [27:0] ra, wa; logic [127:0] wd; logic [31:0] rdv;
        logic mv, re;
        do_access(1'b0, 1'b1, 32'h48, 32'hDEADBEEF, bw, nrd, nwr, ra, wa, wd, rdv, mv, re);
        checks++; if (bw !== 0 || re !== 1'b0) begin failures++;
            $display("FAIL write_hit_busy got=%0d req=%b exp=0/0", bw, re); end
        do_access(1'b1, 1'b0, 32'h48, 32'h0, bw, nrd, nwr, ra, wa, wd, rdv, mv, re);
        checks++; if (bw !== 0 || rdv !== 32'hDEADBEEF) begin failures++;
            $display("FAIL write_readback got=%h busy=%0d exp=deadbeef/0", rdv, bw); end
    endtask

    task automatic test_dirty_miss();
        int bw, nrd, nwr; logic [27:0] ra, wa; logic [127:0] wd; logic [31:0] rdv;
        logic mv, re;
        do_access(1'b1, 1'b0, 32'hC0, 32'h0, bw, nrd, nwr, ra, wa, wd, rdv, mv, re);
        checks++; if (nwr !== 16 || wa !== 28'h0000004) begin failures++;
            $display("FAIL dirty_wb got=%0d/%h exp=16/0000004", nwr, wa); end
        checks++; if (wd[95:64] !== 32'hDEADBEEF) begin failures++;
            $display("FAIL dirty_wb_word got=%h exp=deadbeef", wd[95:64]); end
        checks++; if (wd !== 128'h44444444_DEADBEEF_22222222_11111111) begin failures++;
            $display("FAIL dirty_wb_block got=%h", wd); end
        checks++; if (nrd !== 16 || ra !== 28'h000000C) begin failures++;
            $display("FAIL dirty_fetch got=%0d/%h exp=16/000000c", nrd, ra); end
        checks++; if (bw !== 34 || mv !== 1'b0) begin failures++;
            $display("FAIL dirty_busy_cycles got=%0d moved=%b exp=34/0", bw, mv); end
        checks++; if (rdv !== 32'hAAAAAAAA) begin failures++;
            $display("FAIL dirty_readdata got=%h exp=aaaaaaaa", rdv); end
        checks++; if (mem[8'h04] !== 128'h44444444_DEADBEEF_22222222_11111111) begin
            failures++; $display("FAIL dirty_mem_updated got=%h", mem[8'h04]); end
    endtask

    task automatic test_reset_mid_fetch();
        int bw, nrd, nwr; logic [27:0] ra, wa; logic [127:0] wd; logic [31:0] rdv;
        logic mv, re;
        @(negedge clock);
        cpu_read = 1'b1; cpu_address = 32'h50;
        repeat (7) @(negedge clock);
        #1;
        checks++; if (mif.mem_read !== 1'b1) begin failures++;
            $display("FAIL midfetch_active got=%b exp=1", mif.mem_read); end
        reset = 1'b1;
        #1;
        checks++; if (mif.mem_read !== 1'b0 || cpu_busywait !== 1'b0) begin failures++;
            $display("FAIL midfetch_reset rd=%b busy=%b exp=0/0", mif.mem_read, cpu_busywait);
        end
        cpu_read = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        do_access(1'b1, 1'b0, 32'h44, 32'h0, bw, nrd, nwr, ra, wa, wd, rdv, mv, re);
        checks++; if (bw !== 18 || nrd !== 16) begin failures++;
            $display("FAIL after_reset_miss busy=%0d rd=%0d exp=18/16", bw, nrd); end
        checks++; if (rdv !== 32'h22222222) begin failures++;
            $display("FAIL after_reset_data got=%h exp=22222222", rdv); end
    endtask

    task automatic test_illegal();
        @(negedge clock);
        cpu_read = 1'b1; cpu_write = 1'b1; cpu_address = 32'h60; cpu_writedata = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (cpu_busywait !== 1'b0 || mif.mem_read !== 1'b0 || mif.mem_write !== 1'b0) begin
                failures++;
                $display("FAIL illegal_req cyc=%0d busy=%b rd=%b wr=%b exp=0/0/0", i,
                         cpu_busywait, mif.mem_read, mif.mem_write);
            end
            @(negedge clock);
        end
        cpu_read = 1'b0; cpu_write = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_miss();
        test_read_hit();
        test_write_hit();
        test_dirty_miss();
        test_reset_mid_fetch();
        test_illegal();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
